// File: rtl/sw_char_feeder.sv
// Character source for the core's switch bus: FIFO-buffered bytes are presented
// one at a time using a valid/seq flag pair, acknowledged by a toggle on LEDG[0].
module sw_char_feeder #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_data,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    input  logic [31:0]              i_io_ledg,
    output logic [31:0]              o_io_sw,
    output logic [15:0]              o_sent_count
);
    // state   | meaning
    // IDLE    | nothing presented; pop the head when the FIFO has data
    // PRESENT | character held on the bus with valid=1, waiting for an ack toggle
    // GAP     | valid=0 hold-off of GAP_CYCLES cycles before the next character

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [GW-1:0]   gap_cnt;
    logic            ack_prev;
    logic            ack_evt;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push_ok;
    logic [7:0]      sw_char;
    logic            sw_valid;
    logic            sw_seq;
    logic            overflow;
    logic [15:0]     sent_count;
    logic            unused_ledg;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = (state == IDLE) && !empty;
    assign push_ok = i_wr_en && (!full || pop);
    assign ack_evt = i_io_ledg[0] ^ ack_prev;

    assign unused_ledg  = ^i_io_ledg[31:1];
    assign o_full       = full;
    assign o_level      = count;
    assign o_io_sw      = {21'b0, overflow, sw_seq, sw_valid, sw_char};
    assign o_sent_count = sent_count;

    // Storage carries no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            gap_cnt    <= '0;
            ack_prev   <= 1'b0;
            sw_char    <= 8'h00;
            sw_valid   <= 1'b0;
            sw_seq     <= 1'b0;
            overflow   <= 1'b0;
            sent_count <= 16'h0000;
        end else begin
            ack_prev <= i_io_ledg[0];

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (i_wr_en && full && !pop)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        sw_char  <= mem[rd_ptr];
                        sw_valid <= 1'b1;
                        sw_seq   <= ~sw_seq;
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_evt) begin
                        sw_valid   <= 1'b0;
                        sent_count <= sent_count + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GW'(GAP_CYCLES - 1);
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
